// File: rtl/vm_change_dispenser.sv
// Change dispenser: accepts a change amount over valid/ready and pays it out greedily
// as timed eject2/eject1 coin pulses. Optional running tally of paid units: VM_CHG_TALLY_EN.
module vm_change_dispenser #(
    parameter int unsigned PULSE_W = 2,
    parameter int unsigned GAP_W   = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       chg_valid,
    input  logic [3:0] chg_amt,
    output logic       chg_ready,
`ifdef VM_CHG_TALLY_EN
    output logic [7:0] tally,
`endif
    output logic       eject2,
    output logic       eject1,
    output logic       busy,
    output logic       done
);

    // Handshake: a change amount transfers on a rising edge where chg_valid && chg_ready;
    // chg_ready is high only in IDLE, and the source must hold chg_amt until then.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PULSE = 2'd1,
        S_GAP   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [3:0] PULSE_LD = 4'(PULSE_W);
    localparam logic [3:0] GAP_LD   = 4'(GAP_W);

    state_t     state_q, state_d;
    logic [3:0] timer_q, timer_d;
    logic [2:0] n2_q, n2_d;
    logic       n1_q, n1_d;
    logic       ready_q, ready_d;
    logic       eject2_q, eject2_d;
    logic       eject1_q, eject1_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
`ifdef VM_CHG_TALLY_EN
    logic [7:0] tally_q, tally_d;
`endif

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        n2_d    = n2_q;
        n1_d    = n1_q;
`ifdef VM_CHG_TALLY_EN
        tally_d = tally_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (chg_valid && ready_q) begin
                    n2_d = chg_amt[3:1];
                    n1_d = chg_amt[0];
                    if (chg_amt == 4'd0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_PULSE;
                        timer_d = PULSE_LD;
                    end
                end
            end
            S_PULSE: begin
                timer_d = timer_q - 4'd1;
                if (timer_q == 4'd1) begin
                    // The coin is counted as paid on its last high cycle.
                    if (n2_q != 3'd0) begin
                        n2_d = n2_q - 3'd1;
`ifdef VM_CHG_TALLY_EN
                        tally_d = tally_q + 8'd2;
`endif
                    end else begin
                        n1_d = 1'b0;
`ifdef VM_CHG_TALLY_EN
                        tally_d = tally_q + 8'd1;
`endif
                    end
                    state_d = S_GAP;
                    timer_d = GAP_LD;
                end
            end
            S_GAP: begin
                timer_d = timer_q - 4'd1;
                if (timer_q == 4'd1) begin
                    if ((n2_q != 3'd0) || n1_q) begin
                        state_d = S_PULSE;
                        timer_d = PULSE_LD;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Outputs are decoded from the next state so they appear registered.
        ready_d  = (state_d == S_IDLE);
        busy_d   = (state_d != S_IDLE);
        done_d   = (state_d == S_DONE);
        eject2_d = (state_d == S_PULSE) && (n2_d != 3'd0);
        eject1_d = (state_d == S_PULSE) && (n2_d == 3'd0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            timer_q  <= 4'd0;
            n2_q     <= 3'd0;
            n1_q     <= 1'b0;
            ready_q  <= 1'b1;
            eject2_q <= 1'b0;
            eject1_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef VM_CHG_TALLY_EN
            tally_q  <= 8'd0;
`endif
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            n2_q     <= n2_d;
            n1_q     <= n1_d;
            ready_q  <= ready_d;
            eject2_q <= eject2_d;
            eject1_q <= eject1_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
`ifdef VM_CHG_TALLY_EN
            tally_q  <= tally_d;
`endif
        end
    end

    assign chg_ready = ready_q;
    assign eject2    = eject2_q;
    assign eject1    = eject1_q;
    assign busy      = busy_q;
    assign done      = done_q;
`ifdef VM_CHG_TALLY_EN
    assign tally     = tally_q;
`endif

endmodule

// File: tb/tb_vm_change_dispenser.sv
// Directed bench for vm_change_dispenser (PULSE_W=2, GAP_W=1); tally checks under VM_CHG_TALLY_EN.
module tb_vm_change_dispenser;

    localparam int P = 2;
    localparam int G = 1;

    logic       clk = 1'b0;
    logic       rst;
    logic       chg_valid;
    logic [3:0] chg_amt;
    logic       chg_ready;
    logic       eject2;
    logic       eject1;
    logic       busy;
    logic       done;
`ifdef VM_CHG_TALLY_EN
    logic [7:0] tally;
`endif

    int n_total = 0;
    int n_bad   = 0;

    vm_change_dispenser #(.PULSE_W(P), .GAP_W(G)) dut (
        .clk       (clk),
        .rst       (rst),
        .chg_valid (chg_valid),
        .chg_amt   (chg_amt),
        .chg_ready (chg_ready),
`ifdef VM_CHG_TALLY_EN
        .tally     (tally),
`endif
        .eject2    (eject2),
        .eject1    (eject1),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Coin i of a payout is high in cycles 1+i*(P+G) .. i*(P+G)+P; 2-unit coins first.
    function automatic void exp_ej(input int amt, input int c, output bit e2, output bit e1);
        int i;
        int ph;
        e2 = 1'b0;
        e1 = 1'b0;
        if (c >= 1) begin
            i  = (c - 1) / (P + G);
            ph = (c - 1) % (P + G);
            if (ph < P) begin
                if (i < amt / 2) e2 = 1'b1;
                else if (i < amt / 2 + amt % 2) e1 = 1'b1;
            end
        end
    endfunction

    // Present an amount in cycle 0; the following rising edge is the accept edge.
    task automatic present(input int amt);
        @(negedge clk);
        chg_valid = 1'b1;
        chg_amt   = 4'(amt);
        chk($sformatf("ready_before_amt%0d", amt), 32'(chg_ready), 32'd1);
    endtask

    // Check cycles 1 .. done+1 of a payout. With hold, the next amount is presented
    // from cycle 1 on and must only be taken once chg_ready returns.
    task automatic watch(input int amt, input bit hold, input int next_amt);
        int k;
        int last;
        bit e2;
        bit e1;
        k    = amt / 2 + amt % 2;
        last = k * (P + G) + 1;
        for (int c = 1; c <= last + 1; c++) begin
            @(negedge clk);
            if (c == 1) begin
                if (hold) begin
                    chg_valid = 1'b1;
                    chg_amt   = 4'(next_amt);
                end else begin
                    chg_valid = 1'b0;
                end
            end
            exp_ej(amt, c, e2, e1);
            chk($sformatf("eject2_a%0d_c%0d", amt, c), 32'(eject2), 32'(e2));
            chk($sformatf("eject1_a%0d_c%0d", amt, c), 32'(eject1), 32'(e1));
            chk($sformatf("overlap_a%0d_c%0d", amt, c), 32'(eject2 & eject1), 32'd0);
            chk($sformatf("done_a%0d_c%0d", amt, c), 32'(done), 32'(c == last));
            chk($sformatf("busy_a%0d_c%0d", amt, c), 32'(busy), 32'(c <= last));
            chk($sformatf("ready_a%0d_c%0d", amt, c), 32'(chg_ready), 32'(c > last));
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst       = 1'b1;
        chg_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", 32'(chg_ready), 32'd1);
        chk("rst_eject2", 32'(eject2), 32'd0);
        chk("rst_eject1", 32'(eject1), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
`ifdef VM_CHG_TALLY_EN
        chk("rst_tally", 32'(tally), 32'd0);
`endif
        rst = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        chg_valid = 1'b0;
        chg_amt   = 4'd0;
        do_reset();

        // amt=5: eject2 cycles 1-2, 4-5; eject1 7-8; done 10
        present(5);
        watch(5, 1'b0, 0);

        // amt=0: no pulses, done cycle 1, ready cycle 2
        present(0);
        watch(0, 1'b0, 0);

        // amt=15: seven 2-unit coins then one 1-unit coin, done cycle 25
        present(15);
        watch(15, 1'b0, 0);

        // amt=4 with amt=3 held during payout; 3 is taken only after done
        present(4);
        watch(4, 1'b1, 3);
        watch(3, 1'b0, 0);

        // amt=6 aborted by rst in cycle 4
        present(6);
        for (int c = 1; c <= 4; c++) begin
            bit e2;
            bit e1;
            @(negedge clk);
            if (c == 1) chg_valid = 1'b0;
            exp_ej(6, c, e2, e1);
            chk($sformatf("abort_eject2_c%0d", c), 32'(eject2), 32'(e2));
            chk($sformatf("abort_eject1_c%0d", c), 32'(eject1), 32'(e1));
        end
        rst = 1'b1;
        @(negedge clk);
        chk("abort_eject2_c5", 32'(eject2), 32'd0);
        chk("abort_eject1_c5", 32'(eject1), 32'd0);
        chk("abort_busy_c5", 32'(busy), 32'd0);
        chk("abort_done_c5", 32'(done), 32'd0);
        rst = 1'b0;
        for (int c = 6; c <= 16; c++) begin
            @(negedge clk);
            chk($sformatf("abort_done_c%0d", c), 32'(done), 32'd0);
            chk($sformatf("abort_ready_c%0d", c), 32'(chg_ready), 32'd1);
            chk($sformatf("abort_ej_c%0d", c), 32'(eject2 | eject1), 32'd0);
        end
`ifdef VM_CHG_TALLY_EN
        chk("abort_tally", 32'(tally), 32'd0);

        present(5);
        watch(5, 1'b0, 0);
        chk("tally_after_5", 32'(tally), 32'd5);
        present(15);
        watch(15, 1'b0, 0);
        chk("tally_after_5_15", 32'(tally), 32'd20);
        do_reset();
        for (int j = 0; j < 13; j++) begin
            present(15);
            watch(15, 1'b0, 0);
        end
        chk("tally_13x15", 32'(tally), 32'd195);
        for (int j = 0; j < 5; j++) begin
            present(15);
            watch(15, 1'b0, 0);
        end
        chk("tally_18x15_wrap", 32'(tally), 32'd14);
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
